// File: rtl/transmitter.sv
// Frame-link transmitter: serialises 16-bit words MSB first onto dClk/data/sync,
// fed from a single-word holding buffer, with dClk divided down from cClk.
module transmitter #(
  parameter int DIV      = 4,
  parameter int WORDS    = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic        cClk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] word,
  input  logic        load,
  output logic        empty,
  output logic        dClk,
  output logic        data,
  output logic        sync,
  output logic        underrun,
  output logic        frameEnd
);

  localparam int CELL     = 2 * DIV;
  localparam int SYNC_CYC = SYNC_LEN * CELL;
  localparam int CW       = $clog2(SYNC_CYC + CELL + 1);
  localparam int WW       = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, GAP, SHIFT} stateType;

  stateType        state;
  stateType        nextState;
  logic [CW-1:0]   cnt;
  logic [3:0]      bitIdx;
  logic [WW-1:0]   wordIdx;
  logic [15:0]     holdBuf;
  logic [15:0]     shiftReg;
  logic            phaseDone;
  logic            lastBit;
  logic            wordStart;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    nextState = state;
    phaseDone = 1'b0;
    dClk      = 1'b0;
    sync      = 1'b0;
    data      = 1'b0;
    lastBit   = (bitIdx == 4'd0) && (wordIdx == WW'(WORDS - 1));
    wordStart = (state == SHIFT) && (bitIdx == 4'd15) && (cnt == '0);

    case (state)
      IDLE: begin
        if (enable) nextState = SYNC;
      end
      SYNC: begin
        sync      = 1'b1;
        phaseDone = (cnt == CW'(SYNC_CYC - 1));
        if (phaseDone) nextState = GAP;
      end
      GAP: begin
        phaseDone = (cnt == CW'(CELL - 1));
        if (phaseDone) nextState = SHIFT;
      end
      SHIFT: begin
        phaseDone = (cnt == CW'(CELL - 1));
        dClk      = (cnt < CW'(DIV));
        // The word is still in the buffer during the first cycle of bit 15.
        if (wordStart) data = empty ? 1'b0 : holdBuf[15];
        else           data = shiftReg[bitIdx];
        if (phaseDone && lastBit) nextState = enable ? SYNC : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      wordIdx  <= '0;
      // NOTE: the buffer and shift register are reset too, so data is never X
      // even if a word starts before anything was loaded.
      holdBuf  <= '0;
      shiftReg <= '0;
      empty    <= 1'b1;
      underrun <= 1'b0;
      frameEnd <= 1'b0;
    end else begin
      state    <= nextState;
      frameEnd <= (state == SHIFT) && phaseDone && lastBit;

      if (nextState != state || phaseDone || state == IDLE) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);

      if (state == GAP) begin
        bitIdx  <= 4'd15;
        wordIdx <= '0;
      end else if (state == SHIFT && phaseDone) begin
        if (bitIdx == 4'd0) begin
          bitIdx  <= 4'd15;
          wordIdx <= wordIdx + WW'(1);
        end else begin
          bitIdx  <= bitIdx - 4'd1;
        end
      end

      if (wordStart) begin
        shiftReg <= empty ? 16'h0000 : holdBuf;
        if (empty) underrun <= 1'b1;
      end
      if (nextState == SYNC && state != SYNC) underrun <= 1'b0;

      // Load and transfer are exclusive: one needs empty=1, the other empty=0.
      if (load && empty) begin
        holdBuf <= word;
        empty   <= 1'b0;
      end else if (wordStart && !empty) begin
        empty   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: frame-offset reference model checked every cycle, plus a
// link decoder that recovers words at dClk falling edges.
module tb_transmitter;

  localparam int DIV      = 4;
  localparam int WORDS    = 2;
  localparam int SYNC_LEN = 2;
  localparam int CELL     = 2 * DIV;
  localparam int SYNC_CYC = SYNC_LEN * CELL;
  localparam int PRE      = (SYNC_LEN + 1) * CELL;
  localparam int WORD_CYC = 16 * CELL;
  localparam int FRAME    = PRE + WORDS * WORD_CYC;
  localparam int LAST     = FRAME - 1;

  logic        cClk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] word;
  logic        load;
  logic        empty, dClk, data, sync, underrun, frameEnd;

  transmitter #(.DIV(DIV), .WORDS(WORDS), .SYNC_LEN(SYNC_LEN)) dut (
    .cClk(cClk), .reset(reset), .enable(enable), .word(word), .load(load),
    .empty(empty), .dClk(dClk), .data(data), .sync(sync),
    .underrun(underrun), .frameEnd(frameEnd)
  );

  always #5 cClk = ~cClk;

  int nCmp = 0;
  int nErr = 0;

  // Reference model: frame offset k (-1 = idle) plus the holding buffer.
  int          k;
  bit          mEmpty;
  logic [15:0] mBuf;
  bit          mUnder;
  bit          mFrameEnd;
  logic [15:0] txWord [WORDS];

  // Link decoder and monitors.
  logic [15:0] rx[$];
  logic [15:0] expQ[$];
  logic [15:0] feedQ[$];
  logic [15:0] sh;
  int          bitCnt;
  logic        prevD = 1'b0, prevS = 1'b0;
  int          cyc = 0;
  int          nSyncRise, nSyncHigh, nFe, nDRise, syncRiseCyc, feCyc;
  logic        urAtSync;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCmp++;
    assert (got === exp)
    else begin
      nErr++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    k = -1; mEmpty = 1; mBuf = '0; mUnder = 0; mFrameEnd = 0;
  endtask

  task automatic clearMon();
    rx.delete(); expQ.delete();
    nSyncRise = 0; nSyncHigh = 0; nFe = 0; nDRise = 0;
    syncRiseCyc = -1; feCyc = -1; urAtSync = 1'bx; bitCnt = 0;
  endtask

  // One cycle: check DUT against the model, run monitors, then advance both over a posedge.
  task automatic tick();
    int s, w, b, nk;
    bit ws;
    logic eS, eD, eDat;
    eS = (k >= 0) && (k < SYNC_CYC);
    eD = 1'b0; eDat = 1'b0; ws = 0;
    if (k >= PRE) begin
      s = k - PRE;
      w = s / WORD_CYC;
      b = 15 - (s % WORD_CYC) / CELL;
      if (s % WORD_CYC == 0) begin
        ws = 1;
        txWord[w] = mEmpty ? 16'h0000 : mBuf;
      end
      eD   = ((s % CELL) < DIV);
      eDat = txWord[w][b];
    end
    check("sync", 16'(sync), 16'(eS));
    check("dClk", 16'(dClk), 16'(eD));
    check("data", 16'(data), 16'(eDat));
    check("frameEnd", 16'(frameEnd), 16'(mFrameEnd));
    check("empty", 16'(empty), 16'(mEmpty));
    check("underrun", 16'(underrun), 16'(mUnder));

    if (sync && !prevS) begin
      nSyncRise++; bitCnt = 0; urAtSync = underrun;
      if (syncRiseCyc < 0) syncRiseCyc = cyc;
    end
    if (sync) nSyncHigh++;
    if (dClk && !prevD) nDRise++;
    if (prevD && !dClk) begin
      sh = {sh[14:0], data};
      bitCnt++;
      if (bitCnt == 16) begin rx.push_back(sh); bitCnt = 0; end
    end
    if (frameEnd) begin
      nFe++;
      if (feCyc < 0) feCyc = cyc;
    end
    prevD = dClk; prevS = sync;

    @(posedge cClk);
    if (!reset) begin
      modelReset();
    end else begin
      if (k < 0 || k == LAST) nk = enable ? 0 : -1;
      else                    nk = k + 1;
      if (ws && mEmpty) mUnder = 1;
      if (nk == 0) mUnder = 0;
      if (load && mEmpty) begin mBuf = word; mEmpty = 0; end
      else if (ws && !mEmpty) mEmpty = 1;
      mFrameEnd = (k == LAST);
      k = nk;
    end
    @(negedge cClk);
    cyc++;
  endtask

  // Run nFrames frames, refilling from feedQ whenever the buffer is free.
  task automatic stream(input int nFrames, input int dropRise);
    int budget;
    budget = nFrames * (FRAME + 20) + 40;
    enable = 1'b1;
    for (int i = 0; i < budget && nFe < nFrames; i++) begin
      load = (empty === 1'b1) && (feedQ.size() != 0);
      if (load) word = feedQ.pop_front();
      tick();
      load = 1'b0;
      if (nSyncRise > 0 && nFe >= nFrames - 1 && nDRise >= dropRise) enable = 1'b0;
    end
    enable = 1'b0;
    load   = 1'b0;
    check("frames_done", 16'(nFe), 16'(nFrames));
    repeat (8) tick();
  endtask

  task automatic checkRx(input string tag);
    logic [15:0] got;
    check({tag, "_count"}, 16'(rx.size()), 16'(expQ.size()));
    foreach (expQ[i]) begin
      got = (i < rx.size()) ? rx[i] : 16'hxxxx;
      check(tag, got, expQ[i]);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; word = '0;
    modelReset();
    clearMon();
    @(negedge cClk);

    // Reset held low, then idle with enable low.
    repeat (3) tick();
    reset = 1'b1;
    repeat (50) tick();
    check("idle_no_dclk", 16'(nDRise), 16'd0);

    // Single frame: preload A5C3, load 0F0F when the buffer frees.
    clearMon();
    word = 16'hA5C3; load = 1'b1; tick(); load = 1'b0;
    feedQ = '{16'h0F0F};
    stream(1, 0);
    check("sync_high_cycles", 16'(nSyncHigh), 16'(SYNC_CYC));
    check("frameEnd_offset", 16'(feCyc - syncRiseCyc), 16'(FRAME));
    check("dclk_pulses", 16'(nDRise), 16'(WORDS * 16));
    expQ = '{16'hA5C3, 16'h0F0F};
    checkRx("single_rx");

    // Loopback across two back-to-back frames.
    clearMon();
    feedQ = '{16'h8001, 16'hFFFF, 16'h0000, 16'h1234};
    stream(2, 0);
    expQ = '{16'h8001, 16'hFFFF, 16'h0000, 16'h1234};
    checkRx("loop_rx");
    check("loop_no_underrun", 16'(underrun), 16'd0);
    check("loop_sync_rises", 16'(nSyncRise), 16'd2);

    // Underrun: empty buffer sends zeros and the flag stays until the next sync.
    clearMon();
    stream(1, 0);
    expQ = '{16'h0000, 16'h0000};
    checkRx("under_rx");
    check("underrun_sticky", 16'(underrun), 16'd1);
    clearMon();
    stream(1, 0);
    check("underrun_clr_at_sync", 16'(urAtSync), 16'd0);

    // Handshake collision: the second load is dropped while the buffer is full.
    clearMon();
    word = 16'h1111; load = 1'b1; tick();
    word = 16'h2222; load = 1'b1; tick();
    load = 1'b0;
    stream(1, 0);
    expQ = '{16'h1111, 16'h0000};
    checkRx("collide_rx");

    // Enable dropped at bit 7 of word 0: frame completes, then stays idle.
    clearMon();
    feedQ = '{16'hABCD, 16'h1357};
    stream(1, 9);
    repeat (40) tick();
    expQ = '{16'hABCD, 16'h1357};
    checkRx("drop_rx");
    check("drop_bits", 16'(nDRise), 16'(WORDS * 16));
    check("drop_no_resync", 16'(nSyncRise), 16'd1);

    // Asynchronous reset pulse in the middle of SHIFT.
    clearMon();
    feedQ.delete();
    word = 16'hFFFF; load = 1'b1; enable = 1'b1;
    for (int i = 0; i < FRAME && nDRise < 3; i++) begin
      tick();
      load = 1'b0;
    end
    check("reached_shift", 16'(nDRise), 16'd3);
    reset = 1'b0;
    #1;
    check("rst_dClk", 16'(dClk), 16'd0);
    check("rst_data", 16'(data), 16'd0);
    check("rst_sync", 16'(sync), 16'd0);
    check("rst_frameEnd", 16'(frameEnd), 16'd0);
    check("rst_underrun", 16'(underrun), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    modelReset();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    nDRise = 0;
    repeat (50) tick();
    check("post_rst_no_dclk", 16'(nDRise), 16'd0);

    // Randomised enable/load traffic against the model.
    clearMon();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(63) == 0) enable = ~enable;
      load = ($urandom_range(3) == 0);
      word = 16'($urandom);
      tick();
    end
    enable = 1'b0; load = 1'b0;
    repeat (FRAME + 10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
